// File: rtl/audio_out_pkg.sv
// Shared constants for the audio output path.
// Sample width default, duty reset value and mode encodings.
package audio_out_pkg;

    localparam int         DW_DEF     = 8;
    localparam logic [7:0] DUTY_RESET = 8'h80;
    localparam logic       MODE_PWM   = 1'b0;
    localparam logic       MODE_DSM   = 1'b1;

endpackage

// File: rtl/sample_fifo2.sv
// Two-entry sample buffer between the producer and the duty register.
// Entry e0 is always the head; e1 is the second-oldest sample.
module sample_fifo2
    import audio_out_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [1:0]    level
);

    localparam logic [1:0] FULL_LVL = 2'(DEPTH);

    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    logic [1:0]    lvl;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (lvl != FULL_LVL);
    assign do_pop  = pop && (lvl != 2'd0);
    assign head    = e0;
    assign level   = lvl;

    // Shift-style storage: pops move e1 forward, pushes fill the first free slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0  <= '0;
            e1  <= '0;
            lvl <= 2'd0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10: begin
                    if (lvl == 2'd0) e0 <= din;
                    else             e1 <= din;
                    lvl <= lvl + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    lvl <= lvl - 2'd1;
                end
                2'b11: begin
                    if (lvl == 2'd1) begin
                        e0 <= din;
                    end else begin
                        e0 <= e1;
                        e1 <= din;
                    end
                end
                2'b00: ;
            endcase
        end
    end

endmodule

// File: rtl/audio_pwm_out.sv
// 1-bit audio output stage: sample FIFO, period counter, duty register,
// and a PWM or first-order delta-sigma modulator driving the pad.
module audio_pwm_out
    import audio_out_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample_in,
    output logic          sample_ready,
    input  logic          mode,
    output logic          pwm_out,
    output logic          underrun,
    output logic [7:0]    underrun_cnt,
    output logic [1:0]    fifo_level
);

    localparam logic [1:0] FULL_LVL = 2'(FIFO_DEPTH);

    logic [DW-1:0] cnt;
    logic [DW-1:0] duty;
    logic [DW-1:0] acc;
    logic [DW-1:0] head;
    logic [DW:0]   sum;
    logic          mode_q;
    logic          boundary;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          pwm_next;

    assign sample_ready = (fifo_level != FULL_LVL);
    assign push         = sample_valid && sample_ready;
    assign boundary     = (cnt == '1);
    assign fifo_empty   = (fifo_level == 2'd0);
    assign pop          = boundary && !fifo_empty;
    assign underrun     = boundary && fifo_empty;
    assign sum          = {1'b0, acc} + {1'b0, duty};

    sample_fifo2 #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (sample_in),
        .pop   (pop),
        .head  (head),
        .level (fifo_level)
    );

    // Free-running period counter, one PWM period per wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt + DW'(1);
    end

    // Duty and mode only change on the period boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty   <= DW'(DUTY_RESET);
            mode_q <= MODE_PWM;
        end else if (boundary) begin
            mode_q <= mode;
            if (pop) duty <= head;
        end
    end

    // Select modulator bit from the mode latched for this period
    always_comb begin
        pwm_next = (cnt < duty);
        if (mode_q == MODE_DSM) pwm_next = sum[DW];
    end

    // Registered pad output; accumulator restarts when the mode switches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out <= 1'b0;
            acc     <= '0;
        end else begin
            pwm_out <= pwm_next;
            if (boundary && (mode != mode_q)) acc <= '0;
            else                              acc <= sum[DW-1:0];
        end
    end

    // Saturating tally of periods that started with no fresh sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            underrun_cnt <= 8'd0;
        else if (underrun && (underrun_cnt != 8'hFF))
            underrun_cnt <= underrun_cnt + 8'd1;
    end

endmodule

// File: tb/tb_audio_pwm_out.sv
// Self-checking bench for audio_pwm_out.
// Scoreboard queue holds accepted samples; duty is judged from pwm_out.
module tb_audio_pwm_out;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_valid = 1'b0;
    logic [7:0] sample_in = 8'h00;
    logic       mode = 1'b0;
    logic       sample_ready;
    logic       pwm_out;
    logic       underrun;
    logic [7:0] underrun_cnt;
    logic [1:0] fifo_level;

    int errors = 0;
    int checks = 0;

    int         tcnt;
    logic [7:0] sb_q[$];
    logic [7:0] exp_duty;
    int         urun_model;

    audio_pwm_out #(.DW(8), .FIFO_DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .sample_ready (sample_ready),
        .mode         (mode),
        .pwm_out      (pwm_out),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    // Reference period counter and scoreboard: pop on boundary before push
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt = 0;
            sb_q.delete();
            exp_duty = 8'h80;
            urun_model = 0;
        end else begin
            if (tcnt == 255) begin
                if (sb_q.size() > 0) exp_duty = sb_q.pop_front();
                else urun_model++;
            end
            if (sample_valid && sample_ready) sb_q.push_back(sample_in);
            tcnt = (tcnt + 1) % 256;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_cnt(input int c);
        while (tcnt != c) @(negedge clk);
    endtask

    task automatic push_sample(input logic [7:0] v);
        int n;
        n = 0;
        sample_valid = 1'b1;
        sample_in = v;
        while (!sample_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        sample_valid = 1'b0;
        if (n >= 600) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: sample %0h never accepted", v);
        end
    endtask

    // Observe one full period of pwm_out (cnt 0..255 -> samples at 1..255,0)
    task automatic count_period(input int toggle_at, output int ones,
                                output int max_run, output int urs,
                                output logic [7:0] exp_d);
        int run;
        wait_cnt(1);
        exp_d = exp_duty;
        ones = 0;
        max_run = 0;
        urs = 0;
        run = 0;
        for (int i = 0; i < 256; i++) begin
            if (tcnt == toggle_at) mode = ~mode;
            if (pwm_out) begin
                ones++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (underrun) urs++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (pwm_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_pwm: got %b expected 0", pwm_out);
        end
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL rst_underrun: got %b expected 0", underrun);
        end
        checks++;
        if (underrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rst_ucnt: got %0d expected 0", underrun_cnt);
        end
        checks++;
        if (fifo_level !== 2'd0) begin
            errors++;
            $display("FAIL rst_level: got %0d expected 0", fifo_level);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (sample_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready: got %b expected 1", sample_ready);
        end
    endtask

    task automatic test_empty_fifo();
        int ones, mr, urs;
        logic [7:0] d;
        do_reset();
        wait_cnt(10);
        push_sample(8'h40);
        checks++;
        if (fifo_level !== 2'd1) begin
            errors++;
            $display("FAIL empty_level: got %0d expected 1", fifo_level);
        end
        wait_cnt(255);
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL empty_no_underrun: got %b expected 0", underrun);
        end
        count_period(-1, ones, mr, urs, d);
        checks++;
        if (ones != int'(d) || ones != 64) begin
            errors++;
            $display("FAIL empty_ones: got %0d expected 64 (sb %0d)", ones, d);
        end
        checks++;
        if (urs != 1) begin
            errors++;
            $display("FAIL empty_next_underrun: got %0d expected 1", urs);
        end
    endtask

    task automatic test_back_to_back();
        int n, ones, mr, urs;
        logic [7:0] d;
        logic [7:0] want[3];
        want[0] = 8'h10;
        want[1] = 8'h20;
        want[2] = 8'h30;
        do_reset();
        wait_cnt(20);
        sample_valid = 1'b1;
        sample_in = 8'h10;
        @(negedge clk);
        checks++;
        if (fifo_level !== 2'd1 || sample_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_lvl1: got lvl %0d rdy %b expected 1 1",
                     fifo_level, sample_ready);
        end
        sample_in = 8'h20;
        @(negedge clk);
        checks++;
        if (fifo_level !== 2'd2 || sample_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_lvl2: got lvl %0d rdy %b expected 2 0",
                     fifo_level, sample_ready);
        end
        sample_in = 8'h30;
        n = 0;
        while (!sample_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300 || tcnt != 0 || fifo_level !== 2'd1) begin
            errors++;
            $display("FAIL b2b_pop: got lvl %0d cnt %0d expected 1 at 0",
                     fifo_level, tcnt);
        end
        @(negedge clk);
        sample_valid = 1'b0;
        checks++;
        if (fifo_level !== 2'd2) begin
            errors++;
            $display("FAIL b2b_lvl2b: got %0d expected 2", fifo_level);
        end
        for (int k = 0; k < 3; k++) begin
            count_period(-1, ones, mr, urs, d);
            checks++;
            if (ones != int'(d) || ones != int'(want[k])) begin
                errors++;
                $display("FAIL b2b_order%0d: got %0d expected %0d",
                         k, ones, want[k]);
            end
        end
    endtask

    task automatic test_underrun_sat();
        int pulses, off, ones, mr, urs;
        logic [7:0] d;
        do_reset();
        pulses = 0;
        off = 0;
        for (int i = 0; i < 300 * 256; i++) begin
            if (i == 100 * 256) begin
                checks++;
                if (underrun_cnt !== 8'd100) begin
                    errors++;
                    $display("FAIL ucnt_100: got %0d expected 100",
                             underrun_cnt);
                end
            end
            if (underrun) begin
                pulses++;
                if (tcnt != 255) off++;
            end
            @(negedge clk);
        end
        checks++;
        if (pulses != 300 || off != 0) begin
            errors++;
            $display("FAIL ur_pulses: got %0d (off %0d) expected 300",
                     pulses, off);
        end
        checks++;
        if (underrun_cnt !== 8'd255 || urun_model != 300) begin
            errors++;
            $display("FAIL ur_sat: got %0d expected 255", underrun_cnt);
        end
        count_period(-1, ones, mr, urs, d);
        checks++;
        if (ones != int'(d) || ones != 128) begin
            errors++;
            $display("FAIL ur_duty: got %0d expected 128", ones);
        end
    endtask

    task automatic test_dsm_density();
        int ones, mr, urs;
        logic [7:0] d;
        do_reset();
        mode = 1'b1;
        push_sample(8'h03);
        push_sample(8'hFF);
        count_period(-1, ones, mr, urs, d);
        checks++;
        if (ones != int'(d) || ones != 3) begin
            errors++;
            $display("FAIL dsm_3: got %0d expected 3", ones);
        end
        checks++;
        if (mr != 1) begin
            errors++;
            $display("FAIL dsm_width: got %0d expected 1", mr);
        end
        count_period(-1, ones, mr, urs, d);
        checks++;
        if (ones != int'(d) || ones != 255) begin
            errors++;
            $display("FAIL dsm_ff: got %0d expected 255", ones);
        end
    endtask

    task automatic test_extremes_mode();
        int ones, mr, urs;
        logic [7:0] d;
        do_reset();
        mode = 1'b0;
        push_sample(8'h00);
        push_sample(8'h40);
        count_period(-1, ones, mr, urs, d);
        checks++;
        if (ones != 0 || d != 8'h00) begin
            errors++;
            $display("FAIL ext_pwm0: got %0d expected 0", ones);
        end
        count_period(100, ones, mr, urs, d);
        checks++;
        if (ones != 64 || mr != 64) begin
            errors++;
            $display("FAIL ext_toggle_hold: got %0d run %0d expected 64 64",
                     ones, mr);
        end
        count_period(-1, ones, mr, urs, d);
        checks++;
        if (ones != 64 || mr != 1) begin
            errors++;
            $display("FAIL ext_toggle_dsm: got %0d run %0d expected 64 1",
                     ones, mr);
        end
        push_sample(8'h00);
        count_period(-1, ones, mr, urs, d);
        checks++;
        if (ones != 0 || d != 8'h00) begin
            errors++;
            $display("FAIL ext_dsm0: got %0d expected 0", ones);
        end
        mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        int ones, mr, urs;
        logic [7:0] d;
        do_reset();
        mode = 1'b0;
        wait_cnt(255);
        @(negedge clk);
        push_sample(8'h11);
        push_sample(8'h22);
        wait_cnt(77);
        checks++;
        if (fifo_level !== 2'd2 || pwm_out !== 1'b1 || underrun_cnt !== 8'd1) begin
            errors++;
            $display("FAIL rmid_pre: got lvl %0d pwm %b ucnt %0d expected 2 1 1",
                     fifo_level, pwm_out, underrun_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (fifo_level !== 2'd0 || pwm_out !== 1'b0 || underrun_cnt !== 8'd0
            || underrun !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: got lvl %0d pwm %b ucnt %0d ur %b",
                     fifo_level, pwm_out, underrun_cnt, underrun);
        end
        @(negedge clk);
        rst = 1'b0;
        count_period(-1, ones, mr, urs, d);
        checks++;
        if (ones != 128 || mr != 128) begin
            errors++;
            $display("FAIL rmid_duty: got %0d run %0d expected 128 128",
                     ones, mr);
        end
        checks++;
        if (urs != 1) begin
            errors++;
            $display("FAIL rmid_discard: got %0d underruns expected 1", urs);
        end
    endtask

    initial begin
        test_reset();
        test_empty_fifo();
        test_back_to_back();
        test_underrun_sat();
        test_dsm_density();
        test_extremes_mode();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audio_pwm_out.md
AUDIO_PWM_OUT -- requirements
Module: audio_pwm_out

Interface
REQ-001 Parameter: DW, default 8, sample and duty width; the PWM period is 2^DW clocks.
REQ-002 Parameter: FIFO_DEPTH, default 2, number of sample buffer entries; only the value 2 is supported.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous assert, active-high.
REQ-005 Port: sample_valid  input  1  producer offers sample_in this cycle.
REQ-006 Port: sample_in  input  DW  unsigned audio sample (filtered LPF output).
REQ-007 Port: sample_ready  output  1  block can accept a sample this cycle.
REQ-008 Port: mode  input  1  0 = PWM, 1 = first-order delta-sigma.
REQ-009 Port: pwm_out  output  1  registered 1-bit audio output to the pad.
REQ-010 Port: underrun  output  1  one-cycle pulse when a period boundary finds the FIFO empty.
REQ-011 Port: underrun_cnt  output  8  saturating count of underrun events.
REQ-012 Port: fifo_level  output  2  current FIFO occupancy, 0..2.

Function
REQ-013 Transfer: a sample transfers when sample_valid and sample_ready are both high in the same cycle; no other condition transfers a sample.
REQ-014 Ready: sample_ready = (fifo_level != 2), combinational from registered occupancy only, with no dependence on sample_valid.
REQ-015 Period counter: cnt (DW bits) increments every clock and wraps from 2^DW-1 to 0.
REQ-016 Boundary: the boundary cycle is cnt == 2^DW-1. On it, if the FIFO is non-empty, pop the head into the duty register.
REQ-017 Underrun at boundary: if the FIFO is empty, duty holds its value, underrun pulses high for exactly that cycle, and underrun_cnt increments, saturating at 255.
REQ-018 Simultaneous push and pop: push at level 1 leaves the level at 1. Push at level 0 on the boundary does not pop the same cycle; the boundary still counts as an underrun.
REQ-019 Mode sampling: mode is sampled into mode_q only on the boundary cycle. A mid-period change takes effect from the next period.
REQ-020 PWM mode: pwm_out(t+1) = (cnt(t) < duty(t)). Duty 0 gives constantly low; duty 255 gives high 255 of every 256 clocks.
REQ-021 Delta-sigma mode: each cycle sum = acc + duty (DW+1 bits); pwm_out <= sum[DW]; acc <= sum[DW-1:0]. Ones density equals duty/2^DW exactly over any 2^DW-cycle window with constant duty.
REQ-022 Accumulator on mode change: acc is cleared when mode_q changes value.
REQ-023 Latency: a sample accepted into an empty FIFO becomes duty at the next boundary and affects pwm_out one cycle later.
REQ-024 FIFO order: samples are consumed strictly in arrival order, with no drops and no duplicates.

Reset
REQ-025 While rst is high: cnt=0, duty=8'h80 (midscale), acc=0, mode_q=0, FIFO empty (fifo_level=0), pwm_out=0, underrun=0, underrun_cnt=0.
REQ-026 Reset mid-period discards buffered samples and restarts the period at cnt=0 on the first clock after release.
REQ-027 sample_ready is high from the first cycle after reset release.

Structure
REQ-028 Shared package audio_out_pkg: DW default, the DUTY_RESET constant (8'h80), and the mode encoding constants MODE_PWM and MODE_DSM.
REQ-029 Sub-module sample_fifo2: a 2-entry FIFO with push, pop, head and level outputs. All other logic stays flat in audio_pwm_out.

Verification
REQ-030 Empty-FIFO sample: reset, then push 8'h40 at cnt=10 -> at the boundary duty becomes 8'h40; next period pwm_out is high for exactly 64 of 256 clocks; no underrun.
REQ-031 Back-pressure: push 3 samples back-to-back before any boundary -> sample_ready goes low after the 2nd; the 3rd is held until the boundary pop; fifo_level sequence is 1, 2, 1, 2.
REQ-032 Underrun saturation: no pushes for 300 periods -> 300 single-cycle underrun pulses; underrun_cnt=255; pwm_out keeps 50% duty (8'h80).
REQ-033 Delta-sigma density: mode=1, duty=8'h03 -> exactly 3 ones per 256 clocks, each ones-pulse 1 cycle wide; duty=8'hFF -> 255 ones per 256.
REQ-034 Extremes and mid-period mode change: duty=0 -> pwm_out constantly 0 in both modes. Toggle mode at cnt=100 -> output behaviour changes only after the next boundary.
REQ-035 Reset mid-operation: assert rst with level=2 at cnt=77 -> all outputs take REQ-025 values at once; after release the period starts at cnt=0 with duty 8'h80.
